// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - EX operand forwarding selects, load-use bubble and multiplier occupancy FSM
// Define HAZARD_STATS_EN to add the saturating stall_cycles counter port.
module fwd_hazard_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int MULT_LAT   = 4
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rs1,
   input  logic [REG_ADDR_W-1:0] ex_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_reg_write,
   input  logic                  ex_mem_read,
   input  logic                  ex_is_mult,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic                  mem_reg_write,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   input  logic                  wb_reg_write,
   output logic [1:0]            fwd_a_sel,
   output logic [1:0]            fwd_b_sel,
   output logic                  stall,
   output logic                  ex_hold,
   output logic                  bubble,
`ifdef HAZARD_STATS_EN
   output logic [15:0]           stall_cycles,
`endif
   output logic                  mult_done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // BUSY exits once the counter reaches MULT_LAT-2, giving MULT_LAT-1 hold cycles in total
   localparam logic [3:0] LAST_CNT = 4'(MULT_LAT - 2);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       mult_hold;
   logic       mult_last;
   logic       load_use;

   function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src,
                                          input logic [REG_ADDR_W-1:0] m_rd,
                                          input logic                  m_we,
                                          input logic [REG_ADDR_W-1:0] w_rd,
                                          input logic                  w_we);
      logic [1:0] sel;
      sel = 2'b00;
      if (m_we && (m_rd != '0) && (m_rd == src)) begin
         sel = 2'b10;
      end else if (w_we && (w_rd != '0) && (w_rd == src)) begin
         sel = 2'b01;
      end
      return sel;
   endfunction

   always_comb begin
      fwd_a_sel = fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
      fwd_b_sel = fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
   end

   always_comb begin
      load_use = ex_mem_read && (ex_rd != '0) &&
                 ((ex_rd == id_rs1) || (ex_rd == id_rs2));
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mult_hold = 1'b0;
      mult_last = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (ex_is_mult) begin
               mult_hold = 1'b1;
               if (MULT_LAT == 2) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_BUSY;
                  cnt_d   = 4'd1;
               end
            end
         end
         ST_BUSY: begin
            mult_hold = 1'b1;
            cnt_d     = cnt_q + 4'd1;
            if (cnt_q == LAST_CNT) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            mult_last = 1'b1;
            cnt_d     = '0;
            state_d   = ST_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // A held ID/EX must not be flushed, so the multiply suppresses the bubble
   always_comb begin
      stall     = arst_n & (mult_hold | load_use);
      ex_hold   = arst_n & mult_hold;
      bubble    = arst_n & load_use & ~mult_hold;
      mult_done = arst_n & mult_last;
   end

`ifdef HAZARD_STATS_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - self-checking bench for fwd_hazard_ctrl
// Define HAZARD_STATS_EN to also exercise the stall counter.
module tb_fwd_hazard_ctrl;
   localparam int AW  = 5;
   localparam int LAT = 4;

   logic          clk = 1'b0;
   logic          arst_n = 1'b0;
   logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic          ex_reg_write, ex_mem_read, ex_is_mult, mem_reg_write, wb_reg_write;
   logic [1:0]    fwd_a_sel, fwd_b_sel;
   logic          stall, ex_hold, bubble, mult_done;
`ifdef HAZARD_STATS_EN
   logic [15:0]   stall_cycles;
`endif

   int checks = 0;
   int errors = 0;
   int m_age  = -1;

   fwd_hazard_ctrl #(.REG_ADDR_W(AW), .MULT_LAT(LAT)) dut (
      .clk(clk), .arst_n(arst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_is_mult(ex_is_mult), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
      .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .stall(stall), .ex_hold(ex_hold), .bubble(bubble),
`ifdef HAZARD_STATS_EN
      .stall_cycles(stall_cycles),
`endif
      .mult_done(mult_done)
   );

   always #5 clk = ~clk;

   // Reference: a multiply is tracked by how many cycles it has been resident in EX
   function automatic int cur_age();
      if (m_age >= 0) return m_age;
      return ex_is_mult ? 0 : -1;
   endfunction

   function automatic logic [1:0] exp_fwd(input logic [AW-1:0] src);
      if (mem_reg_write && mem_rd != 0 && mem_rd == src) return 2'b10;
      if (wb_reg_write && wb_rd != 0 && wb_rd == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic exp_lu();
      return ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
   endfunction

   task automatic advance();
      int a;
      a = cur_age();
      m_age = (!arst_n || a < 0 || a == LAT - 1) ? -1 : a + 1;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
      {ex_reg_write, ex_mem_read, ex_is_mult, mem_reg_write, wb_reg_write} = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      arst_n = 1'b0;
      m_age  = -1;
      @(posedge clk);
      #1;
      arst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      arst_n     = 1'b0;
      ex_is_mult = 1'b1;
      ex_mem_read = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4;
      ex_rs1 = 5'd5; mem_rd = 5'd5; mem_reg_write = 1'b1;
      @(negedge clk);
      checks++;
      if ({stall, ex_hold, bubble, mult_done} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_outs: got %b expected 0000", {stall, ex_hold, bubble, mult_done});
      end
      checks++;
      if (fwd_a_sel !== 2'b10) begin
         errors++;
         $display("FAIL reset_fwd: got %b expected 10", fwd_a_sel);
      end
      do_reset();
      @(negedge clk);
      checks++;
      if ({stall, ex_hold, bubble, mult_done} !== 4'b0000) begin
         errors++;
         $display("FAIL post_reset_idle: got %b expected 0000", {stall, ex_hold, bubble, mult_done});
      end
`ifdef HAZARD_STATS_EN
      checks++;
      if (stall_cycles !== 16'd0) begin
         errors++;
         $display("FAIL reset_stats: got %0d expected 0", stall_cycles);
      end
`endif
   endtask

   task automatic test_fwd_priority();
      clear_inputs();
      ex_rs1 = 5'd5; mem_rd = 5'd5; mem_reg_write = 1'b1; wb_rd = 5'd5; wb_reg_write = 1'b1;
      #1;
      checks++;
      if (fwd_a_sel !== 2'b10) begin
         errors++;
         $display("FAIL fwd_mem_prio: got %b expected 10", fwd_a_sel);
      end
      mem_reg_write = 1'b0;
      #1;
      checks++;
      if (fwd_a_sel !== 2'b01) begin
         errors++;
         $display("FAIL fwd_wb: got %b expected 01", fwd_a_sel);
      end
      ex_rs1 = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0; mem_reg_write = 1'b1;
      #1;
      checks++;
      if (fwd_a_sel !== 2'b00) begin
         errors++;
         $display("FAIL fwd_r0: got %b expected 00", fwd_a_sel);
      end
      ex_rs2 = 5'd9; wb_rd = 5'd9; wb_reg_write = 1'b1; mem_rd = 5'd8;
      #1;
      checks++;
      if (fwd_b_sel !== 2'b01) begin
         errors++;
         $display("FAIL fwd_b_wb: got %b expected 01", fwd_b_sel);
      end
      clear_inputs();
      advance();
   endtask

   task automatic test_load_use();
      clear_inputs();
      ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7;
      @(negedge clk);
      checks++;
      if ({stall, bubble, ex_hold} !== 3'b110) begin
         errors++;
         $display("FAIL lu_stall: got %b expected 110", {stall, bubble, ex_hold});
      end
      advance();
      clear_inputs();
      mem_rd = 5'd7; mem_reg_write = 1'b1; ex_rs2 = 5'd7; id_rs2 = 5'd7;
      @(negedge clk);
      checks++;
      if (fwd_b_sel !== 2'b10 || stall !== 1'b0) begin
         errors++;
         $display("FAIL lu_resolve: got sel=%b stall=%b expected sel=10 stall=0", fwd_b_sel, stall);
      end
      clear_inputs();
      ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL lu_r0: got %b expected 0", stall);
      end
      clear_inputs();
      advance();
   endtask

   task automatic test_mult();
      clear_inputs();
      ex_is_mult = 1'b1;
      for (int i = 0; i < LAT; i++) begin
         @(negedge clk);
         checks++;
         if ({stall, ex_hold, mult_done} !== ((i < LAT - 1) ? 3'b110 : 3'b001)) begin
            errors++;
            $display("FAIL mult_cycle%0d: got %b expected %b", i, {stall, ex_hold, mult_done},
                     (i < LAT - 1) ? 3'b110 : 3'b001);
         end
         advance();
      end
      ex_is_mult = 1'b0;
      @(negedge clk);
      checks++;
      if ({stall, ex_hold, mult_done} !== 3'b000) begin
         errors++;
         $display("FAIL mult_idle: got %b expected 000", {stall, ex_hold, mult_done});
      end
      advance();
   endtask

   task automatic test_back_to_back();
      int n_stall, n_done;
      n_stall = 0; n_done = 0;
      clear_inputs();
      ex_is_mult = 1'b1;
      for (int i = 0; i < 2 * LAT; i++) begin
         @(negedge clk);
         n_stall += int'(stall);
         n_done  += int'(mult_done);
         advance();
      end
      ex_is_mult = 1'b0;
      checks++;
      if (n_stall != 2 * (LAT - 1) || n_done != 2) begin
         errors++;
         $display("FAIL b2b_counts: got stall=%0d done=%0d expected stall=%0d done=2", n_stall, n_done, 2 * (LAT - 1));
      end
      @(negedge clk);
      checks++;
      if ({stall, mult_done} !== 2'b00) begin
         errors++;
         $display("FAIL b2b_idle: got %b expected 00", {stall, mult_done});
      end
      advance();
   endtask

   task automatic test_mult_lu();
      clear_inputs();
      ex_is_mult = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3;
      @(negedge clk);
      checks++;
      if ({stall, ex_hold, bubble} !== 3'b110) begin
         errors++;
         $display("FAIL mult_lu: got %b expected 110", {stall, ex_hold, bubble});
      end
      do_reset();
   endtask

   task automatic test_reset_mid();
      int done_at;
      clear_inputs();
      ex_is_mult = 1'b1;
      advance();
      advance();
      @(negedge clk);
      checks++;
      if (ex_hold !== 1'b1) begin
         errors++;
         $display("FAIL mid_busy: got %b expected 1", ex_hold);
      end
      #1 arst_n = 1'b0;
      m_age = -1;
      #1;
      checks++;
      if ({stall, ex_hold} !== 2'b00) begin
         errors++;
         $display("FAIL mid_reset_now: got %b expected 00", {stall, ex_hold});
      end
      ex_is_mult = 1'b0;
      @(posedge clk);
      #1 arst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if ({stall, mult_done} !== 2'b00) begin
            errors++;
            $display("FAIL mid_idle%0d: got %b expected 00", i, {stall, mult_done});
         end
         advance();
      end
      ex_is_mult = 1'b1;
      done_at = -1;
      for (int i = 0; i < LAT + 2 && done_at < 0; i++) begin
         @(negedge clk);
         if (mult_done) done_at = i;
         advance();
      end
      ex_is_mult = 1'b0;
      checks++;
      if (done_at != LAT - 1) begin
         errors++;
         $display("FAIL mid_restart: got done_at=%0d expected %0d", done_at, LAT - 1);
      end
      advance();
   endtask

   task automatic test_random();
      int a;
      logic lu, hold;
      for (int n = 0; n < 400; n++) begin
         id_rs1 = AW'($urandom_range(0, 3)); id_rs2 = AW'($urandom_range(0, 3));
         ex_rs1 = AW'($urandom_range(0, 3)); ex_rs2 = AW'($urandom_range(0, 3));
         ex_rd  = AW'($urandom_range(0, 3)); mem_rd = AW'($urandom_range(0, 3));
         wb_rd  = AW'($urandom_range(0, 3));
         ex_reg_write  = 1'($urandom);
         mem_reg_write = 1'($urandom); wb_reg_write = 1'($urandom);
         ex_is_mult  = ($urandom_range(0, 5) == 0);
         ex_mem_read = ($urandom_range(0, 2) == 0) && (!ex_is_mult || $urandom_range(0, 7) == 0);
         @(negedge clk);
         a    = cur_age();
         hold = (a >= 0 && a < LAT - 1);
         lu   = exp_lu();
         checks++;
         if (fwd_a_sel !== exp_fwd(ex_rs1) || fwd_b_sel !== exp_fwd(ex_rs2)) begin
            errors++;
            $display("FAIL rnd_fwd%0d: got %b/%b expected %b/%b", n, fwd_a_sel, fwd_b_sel, exp_fwd(ex_rs1), exp_fwd(ex_rs2));
         end
         checks++;
         if ({stall, ex_hold, bubble, mult_done} !== {hold | lu, hold, lu & ~hold, a == LAT - 1}) begin
            errors++;
            $display("FAIL rnd_ctrl%0d: got %b expected %b", n, {stall, ex_hold, bubble, mult_done},
                     {hold | lu, hold, lu & ~hold, a == LAT - 1});
         end
         advance();
      end
      do_reset();
   endtask

`ifdef HAZARD_STATS_EN
   task automatic test_stats();
      do_reset();
      ex_mem_read = 1'b1; ex_rd = 5'd2; id_rs1 = 5'd2;
      advance();
      clear_inputs();
      ex_is_mult = 1'b1;
      for (int i = 0; i < LAT; i++) advance();
      ex_is_mult = 1'b0;
      @(negedge clk);
      checks++;
      if (stall_cycles !== 16'(1 + LAT - 1)) begin
         errors++;
         $display("FAIL stats_count: got %0d expected %0d", stall_cycles, 1 + LAT - 1);
      end
      ex_mem_read = 1'b1; ex_rd = 5'd2; id_rs1 = 5'd2;
      repeat (65540) @(posedge clk);
      #1;
      clear_inputs();
      @(negedge clk);
      checks++;
      if (stall_cycles !== 16'hFFFF) begin
         errors++;
         $display("FAIL stats_sat: got %h expected ffff", stall_cycles);
      end
      do_reset();
   endtask
`endif

   initial begin
      clear_inputs();
      test_reset();
      test_fwd_priority();
      test_load_use();
      test_mult();
      test_back_to_back();
      test_mult_lu();
      test_reset_mid();
      test_random();
`ifdef HAZARD_STATS_EN
      test_stats();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
